over_history_fifo: RTL and testbench

OVER_HISTORY_FIFO -- requirements
Module: over_history_fifo

---
 rtl/over_history_fifo_pkg.sv | 52 +++++
 rtl/over_history_fifo_ram.sv | 23 ++
 rtl/over_history_fifo.sv | 123 ++++++++++++
 tb/tb_over_history_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/over_history_fifo_pkg.sv
// Shared constants and outcome decode for the delivery history FIFO.
package over_history_fifo_pkg;

  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned RECW_DEF  = 10;

  // Outcome code boundaries (4-bit LFSR code)
  localparam logic [3:0] CODE_DOT_MAX   = 4'd2;
  localparam logic [3:0] CODE_ONE_MAX   = 4'd6;
  localparam logic [3:0] CODE_TWO_MAX   = 4'd9;
  localparam logic [3:0] CODE_THREE     = 4'd10;
  localparam logic [3:0] CODE_FOUR      = 4'd11;
  localparam logic [3:0] CODE_SIX       = 4'd12;
  localparam logic [3:0] CODE_EXTRA_MAX = 4'd14;
  localparam logic [3:0] CODE_WICKET    = 4'd15;

  // Runs credited per outcome class
  localparam logic [2:0] RUNS_DOT   = 3'd0;
  localparam logic [2:0] RUNS_ONE   = 3'd1;
  localparam logic [2:0] RUNS_TWO   = 3'd2;
  localparam logic [2:0] RUNS_THREE = 3'd3;
  localparam logic [2:0] RUNS_FOUR  = 3'd4;
  localparam logic [2:0] RUNS_SIX   = 3'd6;

  // Record field positions
  localparam int unsigned REC_TEAM     = 9;
  localparam int unsigned REC_WICKET   = 8;
  localparam int unsigned REC_EXTRA    = 7;
  localparam int unsigned REC_RUNS_LSB = 4;
  localparam int unsigned REC_IDX_LSB  = 1;

  typedef struct packed {
    logic [2:0] runs;
    logic       extra;
    logic       wicket;
  } outcome_t;

  function automatic outcome_t decode_outcome(input logic [3:0] code);
    outcome_t o;
    o = '0;
    if (code <= CODE_DOT_MAX)        o.runs = RUNS_DOT;
    else if (code <= CODE_ONE_MAX)   o.runs = RUNS_ONE;
    else if (code <= CODE_TWO_MAX)   o.runs = RUNS_TWO;
    else if (code == CODE_THREE)     o.runs = RUNS_THREE;
    else if (code == CODE_FOUR)      o.runs = RUNS_FOUR;
    else if (code == CODE_SIX)       o.runs = RUNS_SIX;
    else if (code <= CODE_EXTRA_MAX) o.extra = 1'b1;
    else if (code == CODE_WICKET)    o.wicket = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/over_history_fifo_ram.sv
// DEPTH x RECW record storage: synchronous write, asynchronous read.
module history_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned RECW  = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [RECW-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [RECW-1:0]          rdata
);

  logic [RECW-1:0] mem [DEPTH];

  // Store one record per accepted write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/over_history_fifo.sv
// Delivery history FIFO with per-over run tracking.
module over_history_fifo
  import over_history_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned RECW  = RECW_DEF
) (
  input  logic                   clk_fpga,
  input  logic                   reset,
  input  logic                   delivery,
  input  logic                   teamSwitch,
  input  logic [3:0]             lfsr_out,
  input  logic                   inningOver,
  input  logic                   gameOver,
  input  logic                   clear,
  input  logic                   rd_en,
  output logic [RECW-1:0]        rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [7:0]             over_runs,
  output logic [7:0]             last_over_runs,
  output logic                   over_done
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     cnt;
  logic [2:0]      ball_idx;
  logic            team_q;
  outcome_t        oc;
  logic            wr_req, do_wr, do_rd, legal, team_chg, over_end;
  logic [8:0]      run_sum;
  logic [7:0]      run_sat;
  logic [RECW-1:0] rec, ram_rdata;

  history_ram #(.DEPTH(DEPTH), .RECW(RECW)) u_ram (
    .clk   (clk_fpga),
    .we    (do_wr),
    .waddr (wr_ptr),
    .wdata (rec),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Decode the delivery, qualify write/pop, and assemble the record
  always_comb begin
    oc       = decode_outcome(lfsr_out);
    legal    = !oc.extra;
    wr_req   = delivery && !inningOver && !gameOver;
    team_chg = teamSwitch ^ team_q;
    full     = (cnt == DEPTH_CNT);
    empty    = (cnt == '0);
    // A full FIFO still accepts a write when the same cycle pops the head
    do_rd    = rd_en && !empty && !clear;
    do_wr    = wr_req && (!full || rd_en) && !clear;
    over_end = wr_req && legal && (ball_idx == 3'd5);
    run_sum  = {1'b0, over_runs} + {6'd0, oc.runs};
    run_sat  = run_sum[8] ? 8'hFF : run_sum[7:0];
    rec                          = '0;
    rec[REC_TEAM]                = teamSwitch;
    rec[REC_WICKET]              = oc.wicket;
    rec[REC_EXTRA]               = oc.extra;
    rec[REC_RUNS_LSB +: 3]       = oc.runs;
    rec[REC_IDX_LSB +: 3]        = ball_idx;
  end

  // Pointer, occupancy and sticky overflow state
  always_ff @(posedge clk_fpga) begin
    if (reset || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (wr_req && full && !rd_en) overflow <= 1'b1;
    end
  end

  // Over tracking: ball index, running total, completed-over latch
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      over_runs      <= '0;
      last_over_runs <= '0;
      over_done      <= 1'b0;
      ball_idx       <= '0;
      team_q         <= teamSwitch;
    end else begin
      team_q    <= teamSwitch;
      over_done <= over_end;
      if (over_end) last_over_runs <= run_sat;
      // Team change zeroes the tally even if a ball is bowled this cycle
      if (team_chg) begin
        over_runs <= '0;
        ball_idx  <= '0;
      end else if (wr_req) begin
        if (over_end) begin
          over_runs <= '0;
          ball_idx  <= '0;
        end else begin
          over_runs <= run_sat;
          if (legal) ball_idx <= ball_idx + 3'd1;
        end
      end
    end
  end

  assign rd_data  = empty ? '0 : ram_rdata;
  assign rd_valid = !empty;
  assign count    = cnt;

endmodule

// File: tb/tb_over_history_fifo.sv
// Directed self-checking bench for over_history_fifo.
module tb_over_history_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk_fpga = 1'b0;
  logic       reset = 1'b1, delivery = 1'b0, teamSwitch = 1'b0;
  logic [3:0] lfsr_out = 4'd0;
  logic       inningOver = 1'b0, gameOver = 1'b0, clear = 1'b0, rd_en = 1'b0;
  logic [9:0] rd_data;
  logic       rd_valid, full, empty, overflow, over_done;
  logic [4:0] count;
  logic [7:0] over_runs, last_over_runs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] m_q[$];
  logic [2:0] m_idx;

  over_history_fifo #(.DEPTH(DEPTH), .RECW(10)) dut (
    .clk_fpga(clk_fpga), .reset(reset), .delivery(delivery), .teamSwitch(teamSwitch),
    .lfsr_out(lfsr_out), .inningOver(inningOver), .gameOver(gameOver), .clear(clear),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .full(full),
    .empty(empty), .overflow(overflow), .over_runs(over_runs),
    .last_over_runs(last_over_runs), .over_done(over_done)
  );

  always #5 clk_fpga = ~clk_fpga;

  function automatic logic [9:0] exp_rec(input logic [3:0] c, input logic t, input logic [2:0] i);
    logic [2:0] r;
    logic x, w;
    r = 3'd0; x = 1'b0; w = 1'b0;
    case (c)
      4'd3, 4'd4, 4'd5, 4'd6: r = 3'd1;
      4'd7, 4'd8, 4'd9:       r = 3'd2;
      4'd10:                  r = 3'd3;
      4'd11:                  r = 3'd4;
      4'd12:                  r = 3'd6;
      4'd13, 4'd14:           x = 1'b1;
      4'd15:                  w = 1'b1;
      default:                r = 3'd0;
    endcase
    return {t, w, x, r, i, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; delivery = 1'b0; clear = 1'b0; rd_en = 1'b0;
    inningOver = 1'b0; gameOver = 1'b0; teamSwitch = 1'b0;
    tick(); tick();
    reset = 1'b0;
    m_q.delete();
    m_idx = 3'd0;
  endtask

  // One accepted delivery; the model pops first (if rd_en and non-empty) then pushes if room
  task automatic bowl(input logic [3:0] c);
    logic [9:0] r;
    r = exp_rec(c, teamSwitch, m_idx);
    if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
    if (m_q.size() < DEPTH) m_q.push_back(r);
    if (c != 4'd13 && c != 4'd14) m_idx = (m_idx == 3'd5) ? 3'd0 : m_idx + 3'd1;
    lfsr_out = c; delivery = 1'b1;
    tick();
    delivery = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (m_q.size() > 0) void'(m_q.pop_front());
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (rd_data !== 10'h000) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 000", rd_data); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (over_runs !== 8'd0) begin n_fail++; $display("FAIL reset_over_runs: got %0d expected 0", over_runs); end
    n_checks++; if (last_over_runs !== 8'd0) begin n_fail++; $display("FAIL reset_last_over_runs: got %0d expected 0", last_over_runs); end
    n_checks++; if (over_done !== 1'b0) begin n_fail++; $display("FAIL reset_over_done: got %b expected 0", over_done); end
  endtask

  task automatic test_basic();
    logic [9:0] heads [4];
    heads = '{10'h010, 10'h062, 10'h084, 10'h104};
    do_reset();
    rd_en = 1'b1;  // pop request while empty must be ignored, write accepted
    bowl(4'd3);
    rd_en = 1'b0;
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL wr_pop_empty_count: got %0d expected 1", count); end
    n_checks++; if (rd_data !== 10'h010) begin n_fail++; $display("FAIL first_latency: got %h expected 010", rd_data); end
    bowl(4'd12); bowl(4'd13); bowl(4'd15);
    n_checks++; if (count !== 5'd4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", count); end
    n_checks++; if (rd_data !== 10'h010) begin n_fail++; $display("FAIL basic_head: got %h expected 010", rd_data); end
    n_checks++; if (over_runs !== 8'd7) begin n_fail++; $display("FAIL basic_over_runs: got %0d expected 7", over_runs); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rd_data !== heads[i]) begin n_fail++; $display("FAIL basic_drain[%0d]: got %h expected %h", i, rd_data, heads[i]); end
      pop();
    end
    pop();  // pop while empty
    n_checks++; if (count !== 5'd0 || overflow !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL pop_empty: got count %0d ovf %b empty %b expected 0 0 1", count, overflow, empty); end
  endtask

  task automatic test_over_complete();
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bowl(4'd11);
      if (over_done === 1'b1) pulses++;
      if (i == 5) begin
        n_checks++; if (over_done !== 1'b1) begin n_fail++; $display("FAIL over_done_timing: got %b expected 1", over_done); end
      end
    end
    tick();
    if (over_done === 1'b1) pulses++;
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL over_done_pulses: got %0d expected 1", pulses); end
    n_checks++; if (last_over_runs !== 8'd24) begin n_fail++; $display("FAIL last_over_runs: got %0d expected 24", last_over_runs); end
    n_checks++; if (over_runs !== 8'd0) begin n_fail++; $display("FAIL over_runs_cleared: got %0d expected 0", over_runs); end
    for (int i = 0; i < 5; i++) pop();
    n_checks++; if (rd_data !== 10'h04A) begin n_fail++; $display("FAIL sixth_record: got %h expected 04a", rd_data); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) bowl(4'(i));
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b expected 1", full); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d expected 16", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (rd_data !== m_q[0]) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, rd_data, m_q[0]); end
      pop();
    end
    n_checks++; if (empty !== 1'b1 || rd_data !== 10'h000) begin n_fail++; $display("FAIL ovf_drained: got empty %b data %h expected 1 000", empty, rd_data); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_full_wr_rd();
    logic [9:0] tail;
    do_reset();
    for (int i = 0; i < DEPTH; i++) bowl(4'((i * 5) % 16));
    rd_en = 1'b1;
    bowl(4'd12);
    rd_en = 1'b0;
    tail = m_q[DEPTH-1];
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fullrw_count: got %0d expected 16", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullrw_overflow: got %b expected 0", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (rd_data !== m_q[0]) begin n_fail++; $display("FAIL fullrw_drain[%0d]: got %h expected %h", i, rd_data, m_q[0]); end
      if (i == DEPTH - 1) begin
        n_checks++; if (rd_data !== tail) begin n_fail++; $display("FAIL fullrw_tail: got %h expected %h", rd_data, tail); end
      end
      pop();
    end
  endtask

  task automatic test_team_switch();
    do_reset();
    bowl(4'd3); bowl(4'd3);
    teamSwitch = 1'b1;
    tick();
    m_idx = 3'd0;
    bowl(4'd7);
    n_checks++; if (over_runs !== 8'd2) begin n_fail++; $display("FAIL switch_over_runs: got %0d expected 2", over_runs); end
    teamSwitch = 1'b0;  // change coincides with a write: old index used, then zeroed
    bowl(4'd3);
    m_idx = 3'd0;
    n_checks++; if (over_runs !== 8'd0) begin n_fail++; $display("FAIL switch_coincide_runs: got %0d expected 0", over_runs); end
    bowl(4'd3);
    n_checks++; if (m_q.size() != 5 || m_q[2] !== 10'h220 || m_q[3] !== 10'h012 || m_q[4] !== 10'h010) begin n_fail++; $display("FAIL switch_model: got %h %h %h expected 220 012 010", m_q[2], m_q[3], m_q[4]); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rd_data !== m_q[0]) begin n_fail++; $display("FAIL switch_drain[%0d]: got %h expected %h", i, rd_data, m_q[0]); end
      pop();
    end
  endtask

  task automatic test_inhibit_clear();
    do_reset();
    bowl(4'd3); bowl(4'd3);
    gameOver = 1'b1; lfsr_out = 4'd12; delivery = 1'b1; tick(); delivery = 1'b0; gameOver = 1'b0;
    inningOver = 1'b1; lfsr_out = 4'd12; delivery = 1'b1; tick(); delivery = 1'b0; inningOver = 1'b0;
    n_checks++; if (count !== 5'd2) begin n_fail++; $display("FAIL inhibit_count: got %0d expected 2", count); end
    n_checks++; if (over_runs !== 8'd2) begin n_fail++; $display("FAIL inhibit_over_runs: got %0d expected 2", over_runs); end
    for (int i = 0; i < DEPTH - 1; i++) bowl(4'd0);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clear_pre_overflow: got %b expected 1", overflow); end
    clear = 1'b1; delivery = 1'b1; lfsr_out = 4'd13; rd_en = 1'b1;
    tick();
    clear = 1'b0; delivery = 1'b0; rd_en = 1'b0;
    m_q.delete();
    n_checks++; if (empty !== 1'b1 || count !== 5'd0) begin n_fail++; $display("FAIL clear_empty: got empty %b count %0d expected 1 0", empty, count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clear_overflow: got %b expected 0", overflow); end
    n_checks++; if (rd_data !== 10'h000) begin n_fail++; $display("FAIL clear_rd_data: got %h expected 000", rd_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_over_complete();
    test_overflow();
    test_full_wr_rd();
    test_team_switch();
    test_inhibit_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
